audio_sample_player: RTL
========================

# audio_sample_player

Plays short 8-bit PCM effect samples from a synchronous sample ROM and emits them as a 1-bit PWM stream for the board's audio pin. Sits directly downstream of the game controller: consumes its registered sample index and one-cycle trigger pulse. A per-sample directory at the bottom of the ROM supplies start address and length, so the sample set can change without touching RTL.

## Interface
- `SAMPLE_BITS`, default 3: width of the sample index; directory holds 2^SAMPLE_BITS entries.
- `ADDR_W`, default 16: sample ROM address width.
- `CLK_DIV`, default 6250: clocks per output sample (50 MHz / 8 kHz); legal range 16..65535.
- `CLK` in, 1: system clock, single domain.
- `RESET` in, 1: synchronous, active-high reset.
- `AUDIO_SELECT` in, SAMPLE_BITS: sample index; sampled only when `AUDIO_TRIGGER` is high.
- `AUDIO_TRIGGER` in, 1: one-cycle start pulse.
- `ROM_ADDR` out, ADDR_W: registered ROM address.
- `ROM_DATA` in, 8: ROM byte. Synchronous ROM: the address is registered at edge n, and data is sampled by this block at edge n+1.
- `SAMPLE_OUT` out, 8: current unsigned sample; 8'h80 is silence.
- `AUDIO_PWM` out, 1: registered PWM output.
- `PLAYING` out, 1: high from trigger acceptance until return to idle.

## Operation
- Directory: entry s occupies bytes 4s..4s+3 as start[15:8], start[7:0], len[15:8], len[7:0]. Addresses are zero-extended to ADDR_W. Start and len are big-endian 16-bit values, truncated to ADDR_W for start.
- States and transitions:
  - IDLE: on an accepted trigger, go to DIR.
  - DIR: issue four directory addresses on consecutive cycles and latch the four returned bytes. Then go to PLAY, or to IDLE if len = 0.
  - PLAY: once per tick, issue ROM_ADDR = ptr and latch the returned byte into SAMPLE_OUT. Then ptr += 1 and remaining -= 1.
  - TAIL: after the last byte is latched, hold it for one full tick. Then SAMPLE_OUT <= 8'h80 and go to IDLE.
- Tick divider: a 16-bit down-counter. It reloads to CLK_DIV-1 on underflow, and is forced so that the next cycle ticks on entry to PLAY.
- ptr wraps modulo 2^ADDR_W. remaining is 16 bits and is never decremented below 0.
- PWM: an 8-bit free-running counter `pwmCount`. AUDIO_PWM <= (pwmCount < SAMPLE_OUT) every clock; the period is 256 clocks.
- PLAYING is high in DIR, PLAY and TAIL.
- A trigger in IDLE is always accepted. Triggers arriving in other states are handled per Configuration.
- A trigger asserted in the same cycle the block returns to IDLE is accepted.

## Timing
- Reset values:
  - state IDLE
  - ROM_ADDR 0
  - SAMPLE_OUT 8'h80
  - AUDIO_PWM 0
  - PLAYING 0
  - pwmCount 0
  - divider 0
  - ptr and remaining 0
- RESET in any state aborts immediately; the outputs take their reset values at that edge.
- Trigger sampled at edge T:
  - Edges T..T+3: ROM_ADDR = 4s, 4s+1, 4s+2, 4s+3.
  - Edges T+2..T+5: directory bytes latched.
  - Edge T: PLAYING goes high.
  - Edge T+6: ROM_ADDR = start.
  - Edge T+7: the ROM registers the address.
  - Edge T+8: SAMPLE_OUT takes the first sample byte.
  - Sample k (0-based) appears at edge T+8+k·CLK_DIV.
- End of a sample of length L:
  - Last byte appears at edge T+8+(L-1)·CLK_DIV.
  - SAMPLE_OUT returns to 8'h80 and PLAYING falls at edge T+8+L·CLK_DIV.
- len = 0: PLAYING falls at edge T+6, ROM_ADDR holds 4s+3, and SAMPLE_OUT stays 8'h80.
- AUDIO_PWM lags SAMPLE_OUT by one clock.

## Configuration
- `AUDIO_RETRIGGER_EN` defined: a trigger in DIR, PLAY or TAIL aborts the current sample. The DIR fetch restarts with the same cycle timing as from IDLE. SAMPLE_OUT holds its current value until the new first byte lands, and PLAYING stays high throughout.
- `AUDIO_RETRIGGER_EN` undefined: triggers outside IDLE are ignored and the current sample plays to completion.

## Test plan
- Reset check: pulse RESET mid-PLAY -> next edge shows SAMPLE_OUT=8'h80, PLAYING=0, AUDIO_PWM=0, ROM_ADDR=0.
- Basic playback:
  - Setup: CLK_DIV=16; directory entry 2 = start 0x0040, len 3; bytes 0x10, 0x20, 0x30; trigger with select 2 at edge T.
  - Required response: ROM_ADDR=8..11 at edges T..T+3. SAMPLE_OUT=0x10 at T+8, 0x20 at T+24, 0x30 at T+40. SAMPLE_OUT=0x80 and PLAYING=0 at T+56.
- Zero length: entry 5 with len 0 -> PLAYING high for edges T..T+5, SAMPLE_OUT constant 8'h80.
- PWM duty: force SAMPLE_OUT=0x40 by playing a sample of constant bytes -> AUDIO_PWM high for exactly 64 of every 256 clocks.
- Mid-sample trigger: trigger select 1 at edge T+30 during the basic playback case.
  - With `AUDIO_RETRIGGER_EN`: ROM_ADDR=4 at edge T+30, and the first byte of sample 1 appears at edge T+38.
  - Without it: the sample 2 sequence is unchanged and the trigger has no effect.
- Pointer wrap: ADDR_W=16, start 0xFFFF, len 2 -> ROM_ADDR 0xFFFF then 0x0000.

Source files
------------

// File: rtl/audio_sample_player.sv
// One-shot PCM effect player: directory lookup, ROM streaming at CLK_DIV clocks per sample, 8-bit PWM out.
// Optional macro AUDIO_RETRIGGER_EN lets a trigger abort and restart a sample that is already playing.
module audio_sample_player #(
    parameter int SAMPLE_BITS = 3,
    parameter int ADDR_W      = 16,
    parameter int CLK_DIV     = 6250
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [SAMPLE_BITS-1:0] AUDIO_SELECT,
    input  logic                   AUDIO_TRIGGER,
    output logic [ADDR_W-1:0]      ROM_ADDR,
    input  logic [7:0]             ROM_DATA,
    output logic [7:0]             SAMPLE_OUT,
    output logic                   AUDIO_PWM,
    output logic                   PLAYING
);
    typedef enum logic [1:0] {ST_IDLE, ST_DIR, ST_PLAY, ST_TAIL} state_t;

    state_t                 state_reg;
    logic [2:0]             dir_cnt_reg;
    logic [SAMPLE_BITS-1:0] sel_reg;
    logic [7:0]             dir_reg [4];
    logic [ADDR_W-1:0]      ptr_reg;
    logic [15:0]            remaining_reg;
    logic [15:0]            div_reg;
    logic [1:0]             lat_pipe_reg;   // marks ROM bytes in flight toward SAMPLE_OUT
    logic [1:0]             end_pipe_reg;   // delays the return to silence to match byte latency
    logic [7:0]             pwm_count_reg;

    logic [15:0]       dir_start;
    logic [15:0]       dir_len;
    logic              tick;
    logic              ending;
    logic              restart;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] base_new;

    assign dir_start = {dir_reg[0], dir_reg[1]};
    assign dir_len   = {dir_reg[2], dir_reg[3]};
    assign tick      = (div_reg == 16'd0);
    assign base_cur  = ADDR_W'({sel_reg, 2'b00});
    assign base_new  = ADDR_W'({AUDIO_SELECT, 2'b00});
    assign ending    = ((state_reg == ST_DIR) && (dir_cnt_reg == 3'd6) && (dir_len == 16'd0)) ||
                       ((state_reg == ST_TAIL) && end_pipe_reg[1]);

`ifdef AUDIO_RETRIGGER_EN
    assign restart = AUDIO_TRIGGER;
`else
    assign restart = AUDIO_TRIGGER && ((state_reg == ST_IDLE) || ending);
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            dir_cnt_reg   <= 3'd0;
            sel_reg       <= '0;
            for (int i = 0; i < 4; i++) dir_reg[i] <= 8'd0;
            ptr_reg       <= '0;
            remaining_reg <= 16'd0;
            div_reg       <= 16'd0;
            lat_pipe_reg  <= 2'b00;
            end_pipe_reg  <= 2'b00;
            pwm_count_reg <= 8'd0;
            ROM_ADDR      <= '0;
            SAMPLE_OUT    <= 8'h80;
            AUDIO_PWM     <= 1'b0;
            PLAYING       <= 1'b0;
        end else begin
            pwm_count_reg <= pwm_count_reg + 8'd1;
            AUDIO_PWM     <= (pwm_count_reg < SAMPLE_OUT);
            lat_pipe_reg  <= {lat_pipe_reg[0], 1'b0};
            end_pipe_reg  <= {end_pipe_reg[0], 1'b0};
            if (lat_pipe_reg[1])
                SAMPLE_OUT <= ROM_DATA;
            if ((state_reg == ST_PLAY) || (state_reg == ST_TAIL))
                div_reg <= tick ? 16'(CLK_DIV - 1) : div_reg - 16'd1;

            if (restart) begin
                state_reg    <= ST_DIR;
                dir_cnt_reg  <= 3'd1;
                sel_reg      <= AUDIO_SELECT;
                ROM_ADDR     <= base_new;
                PLAYING      <= 1'b1;
                lat_pipe_reg <= 2'b00;
                end_pipe_reg <= 2'b00;
                if ((state_reg == ST_TAIL) && end_pipe_reg[1])
                    SAMPLE_OUT <= 8'h80;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                    end
                    ST_DIR: begin
                        dir_cnt_reg <= dir_cnt_reg + 3'd1;
                        if (dir_cnt_reg <= 3'd3)
                            ROM_ADDR <= base_cur | ADDR_W'(dir_cnt_reg);
                        if ((dir_cnt_reg >= 3'd2) && (dir_cnt_reg <= 3'd5))
                            dir_reg[2'(dir_cnt_reg - 3'd2)] <= ROM_DATA;
                        if (dir_cnt_reg == 3'd6) begin
                            if (dir_len == 16'd0) begin
                                state_reg <= ST_IDLE;
                                PLAYING   <= 1'b0;
                            end else begin
                                // First byte is issued here; later bytes follow on divider ticks.
                                ROM_ADDR      <= ADDR_W'(dir_start);
                                ptr_reg       <= ADDR_W'(dir_start) + ADDR_W'(1);
                                remaining_reg <= dir_len - 16'd1;
                                div_reg       <= 16'(CLK_DIV - 1);
                                lat_pipe_reg  <= {lat_pipe_reg[0], 1'b1};
                                state_reg     <= (dir_len == 16'd1) ? ST_TAIL : ST_PLAY;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            ROM_ADDR     <= ptr_reg;
                            ptr_reg      <= ptr_reg + ADDR_W'(1);
                            lat_pipe_reg <= {lat_pipe_reg[0], 1'b1};
                            if (remaining_reg != 16'd0)
                                remaining_reg <= remaining_reg - 16'd1;
                            if (remaining_reg <= 16'd1)
                                state_reg <= ST_TAIL;
                        end
                    end
                    ST_TAIL: begin
                        if (tick)
                            end_pipe_reg <= {end_pipe_reg[0], 1'b1};
                        if (end_pipe_reg[1]) begin
                            SAMPLE_OUT <= 8'h80;
                            PLAYING    <= 1'b0;
                            state_reg  <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end
endmodule
